// File: rtl/one_hz_divider_if.sv
// rtl/one_hz_divider_if.sv - output bundle of the one-second timebase divider
`timescale 1ns/1ps
interface one_hz_divider_if;
  logic OneHz;

  // master drives the divided square wave, slave consumes it
  modport master (output OneHz);
  modport slave  (input  OneHz);
endinterface

// File: rtl/one_hz_divider.sv
// rtl/one_hz_divider.sv - 50% duty square-wave divider producing the traffic-light timebase
`timescale 1ns/1ps
module one_hz_divider #(
  parameter int CLK_HZ = 100_000_000,
  parameter int OUT_HZ = 1
) (
  input  logic             clk,
  input  logic             Sync_Reset,
  one_hz_divider_if.master out_if
);

  // Input cycles per output half-period; HALF=1 degenerates to clk/2.
  localparam int HALF = CLK_HZ / (2 * OUT_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  // Refuse ratios that cannot give an exact 50% duty cycle.
  if ((CLK_HZ % (2 * OUT_HZ)) != 0 || HALF < 1) begin : g_bad_ratio
    $error("one_hz_divider: CLK_HZ must be a positive multiple of 2*OUT_HZ");
  end

  // Power-up values let the divider run from time 0 even without a reset.
  logic [CW-1:0] cnt = '0;
  logic          q   = 1'b0;

  // Half-period counter; wraps on the same edge that toggles the output.
  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      q   <= ~q;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_if.OneHz = q;

endmodule

// File: tb/tb_one_hz_divider.sv
// tb/tb_one_hz_divider.sv - directed self-checking bench for one_hz_divider
`timescale 1ns/1ps
module tb_one_hz_divider;

  logic clk = 1'b0;
  logic Sync_Reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  one_hz_divider_if bus();
  one_hz_divider_if bus2();

  // HALF=5 instance
  one_hz_divider #(.CLK_HZ(10), .OUT_HZ(1)) dut (
    .clk        (clk),
    .Sync_Reset (Sync_Reset),
    .out_if     (bus.master)
  );

  // HALF=1 instance
  one_hz_divider #(.CLK_HZ(2), .OUT_HZ(1)) dut2 (
    .clk        (clk),
    .Sync_Reset (Sync_Reset),
    .out_if     (bus2.master)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev;
    int   rises;
    int   last_t;
    bit   have_last;

    // 1: power-up without reset; after edge k the output is (k/5)%2, clk/2 instance is k%2
    #1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) step();
      check_bit("pwrup_half5", bus.OneHz, logic'((k / 5) % 2));
      check_bit("pwrup_half1", bus2.OneHz, logic'(k % 2));
    end

    // advance to edge 37, which is inside the high phase (edges 35..39)
    for (int k = 30; k < 37; k++) step();
    check_bit("mid_high_before_rst", bus.OneHz, 1'b1);

    // 2: reset sampled on edges 38,39,40; output forced low from the first one
    Sync_Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_bit("rst_held_low", bus.OneHz, 1'b0);
      check_int("rst_held_cnt", int'(dut.cnt), 0);
    end
    Sync_Reset = 1'b0;
    // E0 was the last reset edge: low for E0+1..E0+4, high E0+5..E0+9, low at E0+10
    for (int k = 1; k <= 10; k++) begin
      step();
      check_bit("post_rst_phase", bus.OneHz, (k >= 5 && k <= 9) ? 1'b1 : 1'b0);
    end

    // 3: one reset edge, then 100 free-running edges: 10 rises, 50 ns intervals
    Sync_Reset = 1'b1;
    step();
    Sync_Reset = 1'b0;
    check_bit("run_start_low", bus.OneHz, 1'b0);
    prev = 1'b0;
    rises = 0;
    last_t = 0;
    have_last = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bus.OneHz !== prev) begin
        if (bus.OneHz === 1'b1) rises++;
        if (have_last) check_int("interval_ns", int'($time) - last_t, 50);
        last_t = int'($time);
        have_last = 1'b1;
        prev = bus.OneHz;
      end
    end
    check_int("rise_count", rises, 10);

    // 4: reset held for 50 edges keeps both outputs and the counter at 0
    Sync_Reset = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      check_bit("hold_rst_out", bus.OneHz, 1'b0);
      check_bit("hold_rst_out_half1", bus2.OneHz, 1'b0);
      check_int("hold_rst_cnt", int'(dut.cnt), 0);
    end

    // 5: HALF=1 toggles every edge after release
    Sync_Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_bit("half1_toggle", bus2.OneHz, logic'(k % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/one_hz_divider.md
# one_hz_divider

Clock divider that derives a slow, 50 %-duty square wave (nominally 1 Hz) from the system clock. It provides the timebase for the traffic-light sequencer: downstream logic counts seconds off `OneHz` edges. The block is purely sequential, with one free-running counter and one toggle register, and it is parameterised so simulation can use a scaled-down clock ratio.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: input clock frequency in Hz.
- `OUT_HZ`, default 1: output square-wave frequency in Hz.
- `HALF` (localparam) = `CLK_HZ / (2*OUT_HZ)`: input cycles per output half-period. `CLK_HZ` must be an exact multiple of `2*OUT_HZ`, and `HALF` must be at least 1. Elaboration fails otherwise.
- `CW` (localparam) = max(1, ceil(log2(`HALF`))): counter width.

Ports:
- `clk`, in, 1: system clock. All logic is clocked on its rising edge.
- `Sync_Reset`, in, 1: one clock; reset is synchronous and active-high.
- `OneHz`, out, 1: divided square wave, driven directly from a register.

## Operation
- Internal state:
  - `cnt[CW-1:0]`: half-period counter.
  - `q`: output toggle register. `OneHz` = `q`, with no combinational path.
- Each rising edge of `clk`, in priority order:
  1. `Sync_Reset`=1: `cnt` <= 0 and `q` <= 0.
  2. Otherwise, if `cnt` == `HALF`-1: `cnt` <= 0 and `q` <= ~`q`.
  3. Otherwise: `cnt` <= `cnt`+1.
- Reset values: `OneHz`=0, `cnt`=0.
- Power-up: both registers are initialised to 0 (FPGA init values). `OneHz` is therefore 0, never X, before the first reset, and the divider already runs from time 0 if reset is never asserted.
- Wrap-around: `cnt` never exceeds `HALF`-1. It returns to 0 on the same edge that toggles `q`.
- Degenerate case `HALF`=1: `q` toggles every cycle (output = `clk`/2).
- Reset mid-period: `cnt` and `q` are cleared on that edge, whatever their current values, and the phase restarts from scratch. If reset is held, the output stays 0.
- No clock enable, no gating, and the block adds no other outputs.

## Timing
- Output period = 2*`HALF` `clk` cycles. High time = low time = `HALF` cycles.
- Reference edge E0 is the last rising edge that samples `Sync_Reset`=1.
  - `OneHz` rises at edge E0+`HALF`.
  - `OneHz` falls at edge E0+2*`HALF`.
  - The pattern repeats indefinitely.
- Latency from reset assertion to `OneHz`=0 is one clock edge. `OneHz` changes only just after a rising `clk` edge.
- With the defaults, 100 MHz in gives `HALF`=50_000_000 and `CW`=26, so the output is 1 Hz.

## Test plan
For all scenarios, instantiate with `CLK_HZ`=10 and `OUT_HZ`=1 (`HALF`=5, 10 ns clock), unless stated otherwise.

1. Power-up, no reset for 30 cycles: `OneHz` is 0 for cycles 0–4, 1 for cycles 5–9, and 0 for cycles 10–14. It is never X.
2. Assert `Sync_Reset` for 3 cycles mid-high-phase, then release: `OneHz` is 0 on the first edge of reset and stays 0 while reset is held. It rises exactly 5 edges after the last reset-sampling edge and falls 5 edges after that.
3. Free run for 100 cycles after reset: exactly 10 rising edges. Every high and low interval measures exactly 5 clock periods (50 ns).
4. Hold `Sync_Reset`=1 for 50 cycles: `OneHz` stays 0 throughout, and `cnt` stays 0.
5. With `CLK_HZ`=2 and `OUT_HZ`=1 (`HALF`=1): after reset release, `OneHz` toggles on every edge (0, 1, 0, 1, …).
6. With the default parameters and a 100 MHz clock: after reset, the first rising edge of `OneHz` occurs at 500 ms (50_000_000 cycles) and the period is 1.000 s.
